// File: rtl/knight_pkg.sv
// rtl/knight_pkg.sv - shared types and constants for the command UART wrapper
//
// Holds the two-state command assembly FSM encoding, the default UART bit
// period (50 MHz / 19200 baud) and the response code sent on completion.
package knight_pkg;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } asm_state_t;

    localparam int BAUD_DIV_DEFAULT = 2604;

    localparam logic [7:0] RESP_DONE = 8'hA5;

endpackage

// File: rtl/cmd_uart_wrapper_if.sv
// rtl/cmd_uart_wrapper_if.sv - command/response handshake between wrapper and consumer
//
// Signals:
//   cmd[15:0]    assembled command, first byte in [15:8]
//   cmd_rdy      cmd holds a complete, unconsumed command
//   clr_cmd_rdy  consumer acknowledge, clears cmd_rdy
//   resp[7:0]    response byte, sampled with send_resp
//   send_resp    single-cycle request to transmit resp
//   resp_sent    last response frame has completed
// Modports: master = consumer side, slave = wrapper side.
interface cmd_uart_wrapper_if;

    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    modport master (
        input  cmd, cmd_rdy, resp_sent,
        output clr_cmd_rdy, resp, send_resp
    );

    modport slave (
        output cmd, cmd_rdy, resp_sent,
        input  clr_cmd_rdy, resp, send_resp
    );

endinterface

// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - 8N1 UART receiver and transmitter, LSB first, idle high
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   rx             asynchronous serial input
//   tx             registered serial output
//   rx_data[7:0]   last good received byte
//   rx_rdy         one-cycle pulse the clock after a good stop sample
//   tx_data[7:0]   byte to send, sampled when trmt is accepted
//   trmt           start a frame (ignored while tx_busy)
//   tx_done        high during the final clock of the stop bit
//   tx_busy        a frame is in progress
module uart_xcvr
    import knight_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       tx_done,
    output logic       tx_busy
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    // ---------------- receiver ----------------
    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;
    logic          rx_busy;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [8:0]    rx_shift;

    // Synchronizer and edge-history flops preset to the idle level so that
    // leaving reset with the line high never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            rx_busy  <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_rdy   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            rx_rdy  <= 1'b0;
            if (!rx_busy) begin
                if (rx_prev && !rx_s) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= HALF_M1;
                    rx_bit  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= FULL_M1;
                if (rx_bit == 4'd9) begin
                    // Stop sample: a low stop bit drops the frame silently.
                    rx_busy <= 1'b0;
                    if (rx_s) begin
                        rx_data <= rx_shift[8:1];
                        rx_rdy  <= 1'b1;
                    end
                end else begin
                    // Start and data samples shift in from the top; after
                    // nine samples the data byte sits in [8:1].
                    rx_shift <= {rx_s, rx_shift[8:1]};
                    rx_bit   <= rx_bit + 1'b1;
                end
            end
        end
    end

    // ---------------- transmitter ----------------
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [9:0]    tx_shift;

    assign tx_done = tx_busy && (tx_cnt == '0) && (tx_bit == 4'd9);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
        end else if (!tx_busy) begin
            if (trmt) begin
                tx_busy  <= 1'b1;
                tx_shift <= {1'b1, tx_data, 1'b0};
                tx       <= 1'b0;
                tx_cnt   <= FULL_M1;
                tx_bit   <= '0;
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
        end else if (tx_bit == 4'd9) begin
            tx_busy <= 1'b0;
            tx      <= 1'b1;
        end else begin
            // tx_shift[0] is already on the line; the next bit is [1].
            tx       <= tx_shift[1];
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_bit   <= tx_bit + 1'b1;
            tx_cnt   <= FULL_M1;
        end
    end

endmodule

// File: rtl/cmd_uart_wrapper.sv
// rtl/cmd_uart_wrapper.sv - assembles two UART bytes into a 16-bit command and sends responses
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   RX         asynchronous 8N1 serial input
//   TX         8N1 serial response output
//   host       command/response handshake (slave side): cmd, cmd_rdy,
//              clr_cmd_rdy, resp, send_resp, resp_sent
// Receive and transmit paths are independent and run full duplex.
module cmd_uart_wrapper
    import knight_pkg::*;
#(
    parameter int BAUD_DIV    = BAUD_DIV_DEFAULT,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    output logic                 TX,
    cmd_uart_wrapper_if.slave    host
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMEOUT_M1 = TW'(TIMEOUT_CYC - 1);

    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        tx_done;
    logic        tx_busy;
    logic        tx_accept;

    asm_state_t  state;
    logic [7:0]  hi_byte;
    logic [TW-1:0] timer;
    logic [15:0] cmd_q;
    logic        cmd_rdy_q;
    logic        resp_sent_q;

    assign tx_accept = host.send_resp && !tx_busy;

    uart_xcvr #(
        .BAUD_DIV (BAUD_DIV)
    ) u_xcvr (
        .clk     (clk),
        .rst     (rst),
        .rx      (RX),
        .tx      (TX),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .tx_data (host.resp),
        .trmt    (tx_accept),
        .tx_done (tx_done),
        .tx_busy (tx_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_HI;
            hi_byte     <= '0;
            timer       <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            // Acknowledge first; a completing command below overrides it.
            if (host.clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
            end
            case (state)
                WAIT_HI: begin
                    if (rx_rdy) begin
                        hi_byte   <= rx_data;
                        cmd_rdy_q <= 1'b0;
                        timer     <= '0;
                        state     <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    // A byte arriving on the timeout clock still completes.
                    if (rx_rdy) begin
                        cmd_q     <= {hi_byte, rx_data};
                        cmd_rdy_q <= 1'b1;
                        timer     <= '0;
                        state     <= WAIT_HI;
                    end else if (timer == TIMEOUT_M1) begin
                        hi_byte <= '0;
                        timer   <= '0;
                        state   <= WAIT_HI;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= WAIT_HI;
            endcase
            if (tx_accept) begin
                resp_sent_q <= 1'b0;
            end else if (tx_done) begin
                resp_sent_q <= 1'b1;
            end
        end
    end

    assign host.cmd       = cmd_q;
    assign host.cmd_rdy   = cmd_rdy_q;
    assign host.resp_sent = resp_sent_q;

endmodule

// File: tb/tb_cmd_uart_wrapper.sv
// tb/tb_cmd_uart_wrapper.sv - self-checking bench for cmd_uart_wrapper
module tb_cmd_uart_wrapper;

    localparam int B = 16;
    localparam int T = 1000;
    // Line falls at a negedge; two sync flops plus edge detect, half a bit
    // to the start sample, nine more bits to the stop sample, one clock to cmd_rdy.
    localparam int RX_LAT = 3 + B / 2 + 9 * B + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic tx;

    cmd_uart_wrapper_if host ();

    cmd_uart_wrapper #(
        .BAUD_DIV    (B),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .RX   (rx),
        .TX   (tx),
        .host (host)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         c;
        logic [7:0] b;
    } rx_ev_t;
    rx_ev_t rxq[$];

    logic       p_rst, p_clr, p_send;
    logic [7:0] p_resp;
    always @(posedge clk) begin
        p_rst  = rst;
        p_clr  = host.clr_cmd_rdy;
        p_send = host.send_resp;
        p_resp = host.resp;
    end

    logic        m_lo = 1'b0;
    logic [7:0]  m_hi = '0;
    int          m_hi_c = 0;
    logic [15:0] m_cmd = '0;
    logic        m_rdy = 1'b0;
    logic        m_sent = 1'b0;
    bit          tx_act = 1'b0;
    int          tx_start = 0;
    logic [9:0]  tx_frame = '1;
    logic        exp_tx;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (p_rst) begin
                m_lo   = 1'b0;
                m_cmd  = '0;
                m_rdy  = 1'b0;
                m_sent = 1'b0;
                tx_act = 1'b0;
                rxq.delete();
            end else begin
                if (p_clr) m_rdy = 1'b0;
                // Transmitter is busy through the clock that ends the stop bit.
                if (p_send && (!tx_act || cyc >= tx_start + 10 * B + 1)) begin
                    tx_act   = 1'b1;
                    tx_start = cyc;
                    tx_frame = {1'b1, p_resp, 1'b0};
                    m_sent   = 1'b0;
                end else if (tx_act && cyc == tx_start + 10 * B) begin
                    m_sent = 1'b1;
                end
                if (rxq.size() > 0 && rxq[0].c == cyc) begin
                    if (m_lo && (cyc - m_hi_c) <= T) begin
                        m_cmd = {m_hi, rxq[0].b};
                        m_rdy = 1'b1;
                        m_lo  = 1'b0;
                    end else begin
                        m_hi   = rxq[0].b;
                        m_hi_c = cyc;
                        m_rdy  = 1'b0;
                        m_lo   = 1'b1;
                    end
                    void'(rxq.pop_front());
                end
            end
            exp_tx = (tx_act && (cyc - tx_start) < 10 * B) ? tx_frame[(cyc - tx_start) / B] : 1'b1;
            check("model{tx,rdy,sent,cmd}",
                  {13'd0, tx, host.cmd_rdy, host.resp_sent, host.cmd},
                  {13'd0, exp_tx, m_rdy, m_sent, m_cmd});
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good = 1'b1,
                             input int nbits = 10, input bit chk = 1'b0);
        int n0;
        logic [9:0] fr;
        n0 = cyc;
        fr = {good, b, 1'b0};
        if (good && nbits == 10) rxq.push_back('{n0 + RX_LAT, b});
        for (int i = 0; i < nbits; i++) begin
            rx = fr[i];
            for (int j = 0; j < B; j++) begin
                if (chk && cyc == n0 + RX_LAT - 1) check("rdy_before_done", host.cmd_rdy, 0);
                if (chk && cyc == n0 + RX_LAT)     check("rdy_at_done", host.cmd_rdy, 1);
                @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic pulse_clr();
        host.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        host.clr_cmd_rdy = 1'b0;
    endtask

    task automatic pulse_send(input logic [7:0] r);
        host.resp      = r;
        host.send_resp = 1'b1;
        @(negedge clk);
        host.send_resp = 1'b0;
    endtask

    logic [9:0] a5_line;
    int n0;

    initial begin
        host.clr_cmd_rdy = 1'b0;
        host.send_resp   = 1'b0;
        host.resp        = 8'h00;
        a5_line          = 10'b11_0100_1010;

        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_cmd", host.cmd, 16'h0000);
        check("reset_rdy", host.cmd_rdy, 0);
        check("reset_sent", host.resp_sent, 0);
        rst = 1'b0;
        idle(4);

        // Basic command, with exact completion timing.
        send_byte(8'h20);
        send_byte(8'h00, 1'b1, 10, 1'b1);
        check("cmd_2000", host.cmd, 16'h2000);
        check("rdy_2000", host.cmd_rdy, 1);

        // Acknowledge clears cmd_rdy and keeps cmd.
        idle(7);
        send_byte(8'h43);
        send_byte(8'hF1);
        pulse_clr();
        check("rdy_after_clr", host.cmd_rdy, 0);
        check("cmd_43f1", host.cmd, 16'h43F1);

        // Response frame bit pattern, busy boundary, back-to-back send.
        idle(3);
        pulse_send(8'hA5);
        for (int i = 0; i < 10; i++) begin
            idle(B / 2);
            check($sformatf("a5_bit%0d", i), tx, a5_line[i]);
            if (i == 4) check("sent_during_frame", host.resp_sent, 0);
            if (i < 9) idle(B / 2);
        end
        idle(B / 2 - 1);
        pulse_send(8'h00);
        check("sent_after_stop", host.resp_sent, 1);
        check("tx_idle_after_stop", tx, 1);
        pulse_send(8'h81);
        check("sent_cleared", host.resp_sent, 0);
        check("tx_start_bit", tx, 0);
        idle(40);
        pulse_send(8'hFF);
        for (int i = 0; i < 400 && !host.resp_sent; i++) @(negedge clk);
        check("sent_81_done", host.resp_sent, 1);

        // Timeout drops a lone high byte.
        send_byte(8'h4B);
        idle(1200);
        send_byte(8'h60);
        send_byte(8'h34);
        check("cmd_6034", host.cmd, 16'h6034);
        check("rdy_6034", host.cmd_rdy, 1);

        // Completion and acknowledge in the same clock: set wins.
        idle(5);
        send_byte(8'h11);
        n0 = cyc;
        fork
            send_byte(8'h22);
            begin
                repeat (RX_LAT - 1) @(negedge clk);
                pulse_clr();
            end
        join
        check("rdy_set_wins", host.cmd_rdy, 1);
        check("cmd_1122", host.cmd, 16'h1122);

        // Frame with a low stop bit is ignored.
        send_byte(8'h77);
        send_byte(8'h99, 1'b0);
        idle(8);
        send_byte(8'h88);
        check("cmd_7788", host.cmd, 16'h7788);

        // Reset during transmit and receive.
        pulse_send(8'h3C);
        idle(20);
        send_byte(8'h66, 1'b1, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_tx", tx, 1);
        check("rst_rdy", host.cmd_rdy, 0);
        check("rst_cmd", host.cmd, 16'h0000);
        check("rst_sent", host.resp_sent, 0);
        idle(5);
        send_byte(8'h20);
        send_byte(8'h00);
        check("cmd_2000_after_rst", host.cmd, 16'h2000);

        // Randomized full-duplex traffic.
        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    bit good;
                    good = ($urandom_range(0, 5) != 0);
                    send_byte(8'($urandom), good);
                    if (!good) idle(6);
                    else idle($urandom_range(0, 25));
                end
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    idle($urandom_range(60, 240));
                    if ($urandom_range(0, 2) == 0) pulse_clr();
                    else pulse_send(8'($urandom));
                end
            end
        join
        idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_uart_wrapper.md
CMD_UART_WRAPPER -- requirements
Module: cmd_uart_wrapper

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter BAUD_DIV, default 2604, SHALL set the clocks per UART bit (50 MHz / 19200 baud).
REQ-003 Parameter TIMEOUT_CYC, default 1048576, SHALL set the clocks allowed between high and low command bytes.
REQ-004 Port clk, input, 1 bit, SHALL be the system clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Port RX, input, 1 bit, SHALL be the asynchronous serial input: 8N1, LSB first, idle high.
REQ-007 Port TX, output, 1 bit, SHALL be the serial response output: 8N1, LSB first, idle high.
REQ-008 Port cmd, output, 16 bits, SHALL be the assembled command: first byte received in [15:8], second in [7:0].
REQ-009 Port cmd_rdy, output, 1 bit, SHALL indicate that cmd holds a complete, unconsumed command.
REQ-010 Port clr_cmd_rdy, input, 1 bit, SHALL be the consumer acknowledge that clears cmd_rdy.
REQ-011 Port resp, input, 8 bits, SHALL be the response byte sampled when send_resp is asserted.
REQ-012 Port send_resp, input, 1 bit, SHALL be a single-cycle request to transmit resp.
REQ-013 Port resp_sent, output, 1 bit, SHALL indicate that the last response frame has completed.

Function
REQ-014 RX SHALL pass through a 2-flop synchronizer; a start is a falling edge seen while the receiver is idle.
REQ-015 The receiver SHALL sample each bit at BAUD_DIV/2 into the bit, then every BAUD_DIV clocks, for 10 samples: start, 8 data, stop.
REQ-016 A frame with a stop sample of 0 SHALL be discarded; the assembly FSM SHALL be unaffected.
REQ-017 The assembly FSM SHALL have exactly two states: WAIT_HI and WAIT_LO.
REQ-018 In WAIT_HI, a valid byte SHALL load the high byte register, clear cmd_rdy, and move the FSM to WAIT_LO.
REQ-019 In WAIT_LO, a valid byte SHALL load cmd as {high byte, byte}.
REQ-020 The same WAIT_LO valid byte SHALL set cmd_rdy one clock after the stop sample and return the FSM to WAIT_HI.
REQ-021 In WAIT_LO, a count of TIMEOUT_CYC clocks with no valid byte SHALL return the FSM to WAIT_HI and drop the high byte.
REQ-022 cmd SHALL hold its value until the next complete command; cmd_rdy SHALL stay high until cleared.
REQ-023 clr_cmd_rdy SHALL clear cmd_rdy on the next clock.
REQ-024 If clr_cmd_rdy and command completion occur in the same cycle, the set SHALL win and cmd_rdy SHALL be 1.
REQ-025 send_resp while the transmitter is idle SHALL latch resp and drive the start bit on the next clock.
REQ-026 Each transmitted bit SHALL last exactly BAUD_DIV clocks.
REQ-027 send_resp while the transmitter is busy SHALL be ignored.
REQ-028 resp_sent SHALL clear on an accepted send_resp.
REQ-029 resp_sent SHALL set at the end of the stop bit and stay high until the next accepted send_resp.
REQ-030 Receive and transmit paths SHALL run concurrently and independently (full duplex).

Reset
REQ-031 Reset SHALL force TX=1, cmd=0, cmd_rdy=0, and resp_sent=0.
REQ-032 Reset SHALL force the FSM to WAIT_HI and clear all counters.
REQ-033 Reset SHALL preset the synchronizer flops to 1.
REQ-034 Reset mid-frame SHALL abandon the frame in progress with no partial cmd update.

Structure
REQ-035 Package knight_pkg SHALL hold the assembly FSM state enum, the BAUD_DIV default, and the response code RESP_DONE=8'hA5.
REQ-036 One sub-module, uart_xcvr, SHALL hold the 8N1 receiver and transmitter (rx_data/rx_rdy, tx_data/trmt/tx_done).
REQ-037 cmd_uart_wrapper SHALL hold the assembly FSM, the timeout counter, and the cmd_rdy and resp_sent logic.

Verification (BAUD_DIV=16, TIMEOUT_CYC=1000)
REQ-038 Stimulus: bytes 0x20 then 0x00 -> cmd=16'h2000, cmd_rdy=1 one clock after the second stop sample.
REQ-039 Stimulus: bytes 0x43, 0xF1, then a clr_cmd_rdy pulse -> cmd_rdy=0 next clock, cmd still 16'h43F1.
REQ-040 Stimulus: send_resp with resp=8'hA5 -> TX sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks; resp_sent=1 after the stop bit.
REQ-041 Stimulus: byte 0x4B, idle 1200 clocks, then bytes 0x60, 0x34 -> cmd=16'h6034, no intermediate cmd_rdy.
REQ-042 Stimulus: second byte completes while clr_cmd_rdy=1 -> cmd_rdy=1.
REQ-043 Stimulus: rst pulse mid-transmit and mid-receive -> TX=1 and cmd_rdy=0 next clock; the following bytes 0x20, 0x00 decode as 16'h2000.
